// File: rtl/huffman_bit_packer.sv
// rtl/huffman_bit_packer.sv - packs byte symbols into MSB-first OUT_W-bit words using a canonical Huffman table
// Code lengths are rebuilt from BITS_packed after each load; output words are left-aligned and zero-padded.
module huffman_bit_packer #(
  parameter int SYMBOLS  = 6,
  parameter int MAX_BITS = 16,
  parameter int OUT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [8*MAX_BITS-1:0]     BITS_packed,
  input  logic [8*SYMBOLS-1:0]      HUFFMANVAL_packed,
  input  logic [16*SYMBOLS-1:0]     HUFFMAN_CODE_packed,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_sym,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_word,
  output logic [$clog2(OUT_W):0]    out_nbits,
  output logic                      out_last,
  output logic                      err_unknown,
  output logic                      tbl_valid
);

  localparam int BUF_W  = OUT_W + MAX_BITS;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int NB_W   = $clog2(OUT_W) + 1;
  localparam int LEN_W  = $clog2(MAX_BITS + 1);
  localparam int L_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int IDX_W  = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

  localparam logic [FILL_W-1:0] FULL   = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] BUF_SZ = FILL_W'(BUF_W);

  typedef enum logic [1:0] {IDLE, BUILD, RUN, FLUSH} state_t;

  state_t             state_q;
  logic [7:0]         cnt_q  [MAX_BITS];
  logic [7:0]         val_q  [SYMBOLS];
  logic [15:0]        code_q [SYMBOLS];
  logic [LEN_W-1:0]   len_q  [SYMBOLS];
  logic [IDX_W-1:0]   bidx_q;
  logic [BUF_W-1:0]   buf_q;
  logic [FILL_W-1:0]  fill_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic [OUT_W-1:0]   out_word_q;
  logic [NB_W-1:0]    out_nbits_q;
  logic               err_q;
  logic               tbl_valid_q;

  // Lowest length with codes still unassigned; counts only drain from the low end.
  logic               b_found;
  logic [L_W-1:0]     b_sel;
  always_comb begin
    b_found = 1'b0;
    b_sel   = '0;
    for (int l = MAX_BITS - 1; l >= 0; l--) begin
      if (cnt_q[l] != 8'd0) begin
        b_found = 1'b1;
        b_sel   = L_W'(l);
      end
    end
  end

  logic               hit;
  logic [IDX_W-1:0]   hidx;
  logic [LEN_W-1:0]   sym_len;
  logic [15:0]        sym_code;
  logic               known;
  always_comb begin
    hit  = 1'b0;
    hidx = '0;
    for (int i = SYMBOLS - 1; i >= 0; i--) begin
      if (val_q[i] == in_sym) begin
        hit  = 1'b1;
        hidx = IDX_W'(i);
      end
    end
    sym_len  = len_q[hidx];
    sym_code = code_q[hidx];
    known    = hit && (sym_len != '0);
  end

  // Shifting by BUF_W-len drops the unused upper code bits and parks the code at the top.
  logic [BUF_W-1:0]   ext;
  logic [BUF_W-1:0]   buf_d;
  logic [FILL_W-1:0]  fill_d;
  always_comb begin
    ext    = BUF_W'(sym_code);
    buf_d  = buf_q | ((ext << (BUF_SZ - FILL_W'(sym_len))) >> fill_q);
    fill_d = fill_q + FILL_W'(sym_len);
  end

  logic load_ok;
  assign load_ok  = load && ((state_q == IDLE) ||
                             ((state_q == RUN) && (fill_q == '0) && !out_valid_q));
  assign in_ready = (state_q == RUN) && (fill_q < FULL) && !out_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bidx_q      <= '0;
      buf_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_word_q  <= '0;
      out_nbits_q <= '0;
      err_q       <= 1'b0;
      tbl_valid_q <= 1'b0;
      for (int l = 0; l < MAX_BITS; l++) cnt_q[l] <= '0;
      for (int i = 0; i < SYMBOLS; i++) begin
        val_q[i]  <= '0;
        code_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else if (load_ok) begin
      for (int l = 0; l < MAX_BITS; l++) cnt_q[l] <= BITS_packed[8*l +: 8];
      for (int i = 0; i < SYMBOLS; i++) begin
        val_q[i]  <= HUFFMANVAL_packed[8*i +: 8];
        code_q[i] <= HUFFMAN_CODE_packed[16*i +: 16];
      end
      tbl_valid_q <= 1'b0;
      err_q       <= 1'b0;
      bidx_q      <= '0;
      state_q     <= BUILD;
    end else begin
      case (state_q)
        BUILD: begin
          len_q[bidx_q] <= b_found ? (LEN_W'(b_sel) + LEN_W'(1)) : '0;
          if (b_found) cnt_q[b_sel] <= cnt_q[b_sel] - 8'd1;
          if (bidx_q == IDX_W'(SYMBOLS - 1)) begin
            tbl_valid_q <= 1'b1;
            state_q     <= RUN;
          end else begin
            bidx_q <= bidx_q + IDX_W'(1);
          end
        end
        RUN: begin
          if (out_valid_q) begin
            if (out_ready) begin
              buf_q       <= buf_q << OUT_W;
              fill_q      <= fill_q - FULL;
              out_valid_q <= 1'b0;
            end
          end else if (in_valid && in_ready) begin
            if (known) begin
              buf_q  <= buf_d;
              fill_q <= fill_d;
            end else begin
              err_q <= 1'b1;
            end
            if (in_last) begin
              state_q <= FLUSH;
            end else if (known && (fill_d >= FULL)) begin
              out_valid_q <= 1'b1;
              out_word_q  <= buf_d[BUF_W-1 -: OUT_W];
              out_nbits_q <= NB_W'(OUT_W);
              out_last_q  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_word_q  <= buf_q[BUF_W-1 -: OUT_W];
            if (fill_q > FULL) begin
              out_nbits_q <= NB_W'(OUT_W);
              out_last_q  <= 1'b0;
            end else begin
              out_nbits_q <= NB_W'(fill_q);
              out_last_q  <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              buf_q   <= '0;
              fill_q  <= '0;
              state_q <= RUN;
            end else begin
              buf_q  <= buf_q << OUT_W;
              fill_q <= fill_q - FULL;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_word    = out_word_q;
  assign out_nbits   = out_nbits_q;
  assign out_last    = out_last_q;
  assign err_unknown = err_q;
  assign tbl_valid   = tbl_valid_q;

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream neighbour of fsm_2. Consumes the canonical code table fsm_2 produces (HUFFMAN_CODE_packed) together with the BITS/HUFFMANVAL tables it was built from.
- Encodes a byte-symbol stream into a packed MSB-first bitstream of OUT_W-bit words, with valid/ready on both sides.
- Derives per-symbol code lengths internally from BITS_packed, so fsm_2 needs no extra length output.

Parameters:
- SYMBOLS, 6: number of table entries (matches fsm_2).
- MAX_BITS, 16: maximum code length; BITS_packed byte L-1 holds the count for length L.
- OUT_W, 32: output word width; must satisfy OUT_W >= MAX_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse, normally wired to fsm_2 done; latches all three tables.
- BITS_packed  in  8*MAX_BITS  count of codes per length.
- HUFFMANVAL_packed  in  8*SYMBOLS  symbol byte for each canonical index.
- HUFFMAN_CODE_packed  in  16*SYMBOLS  right-aligned code for each index.
- in_valid  in  1  symbol valid.
- in_ready  out  1  symbol accepted when in_valid && in_ready.
- in_sym  in  8  symbol byte.
- in_last  in  1  marks the final symbol of a block.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream accepts the word.
- out_word  out  OUT_W  packed bits, left-aligned, zero-padded.
- out_nbits  out  clog2(OUT_W)+1  number of meaningful bits in out_word.
- out_last  out  1  final word of a block.
- err_unknown  out  1  sticky: a symbol was dropped.
- tbl_valid  out  1  table built and usable.

Behaviour:
- Reset (rst=0, async): all outputs 0, bit buffer emptied (fill=0), table invalid, state IDLE. Reset mid-block discards all buffered bits with no output.
- States:
  - IDLE: no table.
  - BUILD: length derivation.
  - RUN: accepting symbols.
  - FLUSH: draining after in_last.
- load handling: accepted in IDLE, or in RUN when fill==0 and out_valid==0; ignored in BUILD, FLUSH, or while RUN holds buffered bits. An accepted load registers all three tables, clears tbl_valid and err_unknown, and enters BUILD.
- BUILD:
  - Exactly SYMBOLS cycles, one canonical index per cycle (index 0 first).
  - A running length pointer advances to the next L (1..MAX_BITS) with a non-zero remaining count, skipping zero-count lengths in the same cycle.
  - Index i gets that L and the remaining count decrements.
  - If counts are exhausted, remaining indices get length 0.
  - If counts sum to more than SYMBOLS, the excess is ignored.
  - Then tbl_valid=1 and state goes to RUN.
- Lookup: in_sym is compared against all HUFFMANVAL entries; the lowest matching index wins. Its code is the low len bits of its 16-bit HUFFMAN_CODE entry.
- Bit buffer: width OUT_W+MAX_BITS, MSB-first.
  - An accepted symbol appends its len code bits below the current fill at the clock edge; fill += len.
- in_ready = (state==RUN) && fill<OUT_W && !out_valid. Consequently accept and emit never occur in the same cycle.
- out_valid in RUN: asserted when fill >= OUT_W.
  - out_word = top OUT_W bits, out_nbits=OUT_W, out_last=0.
  - On out_ready, shift left by OUT_W and set fill -= OUT_W.
  - While stalled, out_word/out_nbits/out_last hold stable.
- Unknown symbol (no match, or match with len 0): consumed (handshake completes), no bits appended, err_unknown set to 1 until the next accepted load or reset.
- in_last accepted: append its bits (if any), then go to FLUSH. FLUSH emits words in order:
  - Full words while fill > OUT_W.
  - Then one final word: remaining bits left-aligned, out_nbits=fill (1..OUT_W), out_last=1.
  - If fill==0 on entry, one word with out_word=0, out_nbits=0, out_last=1.
  - On the final handshake: fill=0, state RUN, table retained.
- Latency: a word becomes out_valid the cycle after the accepting edge that makes fill >= OUT_W, or one cycle after FLUSH entry.

Test Plan:
- Table build. Stimulus: rst, then load with BITS L2=2, L3=3, L4=1; HUFFMANVAL "A".."F"; codes A=00, B=01, C=100, D=101, E=110, F=1110. Required: tbl_valid high exactly SYMBOLS+1 cycles after load; in_ready high; err_unknown=0.
- Partial flush. Stimulus: stream "A","B","C","F" with in_last on "F". Required: single word 0x19C00000, out_nbits=11, out_last=1.
- Full words. Stimulus: 16 x "F", in_last on the 16th. Required: two words 0xEEEEEEEE, each out_nbits=32; out_last only on the second; no empty third word; in_ready low while fill=32.
- Backpressure. Stimulus: repeat the previous test with out_ready low for 5 cycles at the first out_valid. Required: out_word stable during the stall; in_ready stays 0; no word lost or duplicated.
- Unknown and short table:
  - Send "Z","A" with in_last on "A". Required: err_unknown=1; word 0x00000000, out_nbits=2, out_last=1.
  - Reload with BITS summing to 5. Required: err_unknown cleared.
  - Then send "F" with in_last. Required: err_unknown=1; zero word, out_nbits=0, out_last=1.
- Reset mid-block. Stimulus: accept "C","D" (6 bits), then assert rst low for 1 cycle. Required: all outputs 0, tbl_valid=0, in_ready=0; a new load rebuilds the table correctly.
